// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle 16-bit shift/rotate sequencer.
// One request is accepted over a valid/ready handshake. The sequencer then applies the
// 1/2/4/8 stages one per clock to a registered operand. The result is held on a
// valid/ready response port until the consumer takes it.
// Optional feature macro: SHIFT_SEQ_EARLY_EXIT_EN. When it is defined, the sequencer
// leaves RUN as soon as no higher amount bits remain set.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_in,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_op,
  input  logic             req_dir,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_out,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic [AMT_W-1:0] r_amt, w_amt_d;
  logic             r_op, w_op_d;
  logic             r_dir, w_dir_d;
  logic [1:0]       r_stage, w_stage_d;

  logic [4:0]       w_step;
  logic [4:0]       w_back;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_moved;
  logic             w_last;

  // Single stage of the datapath: move by 2^stage, or pass through when that amt bit is 0.
  always_comb begin
    w_step = 5'd1 << r_stage;
    w_back = 5'(WIDTH) - w_step;
    w_shl  = r_data << w_step;
    w_shr  = r_data >> w_step;
    if (r_op) begin
      w_moved = r_dir ? w_shr : w_shl;
    end else begin
      // Rotate: OR in the bits that fell off the other end.
      w_moved = r_dir ? (w_shr | (r_data << w_back)) : (w_shl | (r_data >> w_back));
    end
    if (!r_amt[r_stage]) begin
      w_moved = r_data;
    end
  end

  // Decide whether the stage being executed this cycle is the final one.
  always_comb begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    // Finish once no amount bits above the current stage remain.
    w_last = (r_amt >> ({1'b0, r_stage} + 3'd1)) == '0;
`else
    w_last = (r_stage == 2'd3);
`endif
  end

  // Next-state and datapath register updates.
  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_amt_d   = r_amt;
    w_op_d    = r_op;
    w_dir_d   = r_dir;
    w_stage_d = r_stage;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_data_d  = req_in;
          w_amt_d   = req_amt;
          w_op_d    = req_op;
          w_dir_d   = req_dir;
          w_stage_d = 2'd0;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
          w_state_d = (req_amt == '0) ? StDone : StRun;
`else
          w_state_d = StRun;
`endif
        end
      end
      StRun: begin
        w_data_d  = w_moved;
        w_stage_d = r_stage + 2'd1;
        if (w_last) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (resp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers. Reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_amt   <= '0;
      r_op    <= 1'b0;
      r_dir   <= 1'b0;
      r_stage <= 2'd0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_amt   <= w_amt_d;
      r_op    <= w_op_d;
      r_dir   <= w_dir_d;
      r_stage <= w_stage_d;
    end
  end

  // Handshake and result outputs decode directly from state.
  always_comb begin
    req_ready  = (r_state == StIdle);
    resp_valid = (r_state == StDone);
    busy       = (r_state != StIdle);
    resp_out   = (r_state == StDone) ? r_data : '0;
  end

endmodule
